// File: rtl/mem_copy_ctrl_pkg.sv
// Shared types and widths for the memory block-copy engine and its port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_ctrl_if.sv
// Bundle of copy-request, CPU load/store and data-memory signals around the copy engine.
// Latency: n/a (wiring only).
// Backpressure: n/a; cpu_req is the only stall source and is carried here.
// Ports: start/src/dst/len (copy request), cpu_* (CPU memory path), mem_* (memory port),
//        busy/done (engine status). slave = engine side, master = CPU/memory side.
interface mem_copy_ctrl_if #(
  parameter int AW = mem_ctrl_pkg::ADDR_W,
  parameter int DW = mem_ctrl_pkg::DATA_W
) ();

  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;

  logic          cpu_req;
  logic          cpu_wr_en;
  logic          cpu_memread;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;

  logic [DW-1:0] mem_dout;
  logic          mem_wr_en;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  logic          busy;
  logic          done;

  modport slave (
    input  start, src, dst, len,
    input  cpu_req, cpu_wr_en, cpu_memread, cpu_addr, cpu_din,
    input  mem_dout,
    output mem_wr_en, mem_read, mem_addr, mem_din,
    output busy, done
  );

  modport master (
    output start, src, dst, len,
    output cpu_req, cpu_wr_en, cpu_memread, cpu_addr, cpu_din,
    output mem_dout,
    input  mem_wr_en, mem_read, mem_addr, mem_din,
    input  busy, done
  );

endinterface

// File: rtl/mem_copy_ctrl_port_mux.sv
// Selects who drives the single data-memory port: the CPU when cpu_req is high, else the copy engine.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the engine itself holds state while cpu_req is high.
// Ports: reset (blocks any write in a reset cycle), cpu_* and eng_* sources, mem_* to the memory.
module mem_port_mux #(
  parameter int AW = mem_ctrl_pkg::ADDR_W,
  parameter int DW = mem_ctrl_pkg::DATA_W
) (
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr_en,
  input  logic          cpu_memread,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          eng_wr_en,
  input  logic          eng_read,
  input  logic [AW-1:0] eng_addr,
  input  logic [DW-1:0] eng_din,
  output logic          mem_wr_en,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din
);

  always_comb begin
    if (cpu_req) begin
      mem_wr_en = cpu_wr_en;
      mem_read  = cpu_memread;
      mem_addr  = cpu_addr;
      mem_din   = cpu_din;
    end else begin
      mem_wr_en = eng_wr_en;
      mem_read  = eng_read;
      mem_addr  = eng_addr;
      mem_din   = eng_din;
    end
    // A reset cycle must never commit a write, whoever owns the port.
    if (reset) begin
      mem_wr_en = 1'b0;
    end
  end

endmodule

// File: rtl/mem_copy_ctrl.sv
// Block-copy engine: copies len bytes src->dst one read/write pair at a time, sharing the memory port with the CPU.
// Latency: done pulses 2*len+1 cycles after the accepted start (1 cycle for len=0), plus one per stalled cycle.
// Backpressure: cpu_req has absolute priority; the engine holds its RD/WR state for every cycle it is high.
// Ports: clk, reset (sync, active-high); bus = mem_copy_ctrl_if slave (copy request, CPU path, memory port, status).
module mem_copy_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  mem_copy_ctrl_if.slave bus
);

  localparam logic [AW-1:0] ONE = AW'(1);

  copy_state_t   state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;

  logic          eng_wr_en;
  logic          eng_read;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_din;
  logic          done_c;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    eng_wr_en = 1'b0;
    eng_read  = 1'b0;
    eng_addr  = '0;
    eng_din   = '0;
    done_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d   = bus.src;
          dst_d   = bus.dst;
          len_d   = bus.len;
          cnt_d   = '0;
          state_d = (bus.len == '0) ? DONE : RD;
        end
      end

      // Engine strobes are always presented; the mux hides them while the CPU owns the port,
      // so a stalled read simply repeats on the next free cycle.
      RD: begin
        eng_read = 1'b1;
        eng_addr = src_q + cnt_q;
        if (!bus.cpu_req) begin
          buf_d   = bus.mem_dout;
          state_d = WR;
        end
      end

      // buf_q is untouched while stalled, so the write that finally lands is the byte read earlier.
      WR: begin
        eng_wr_en = 1'b1;
        eng_addr  = dst_q + cnt_q;
        eng_din   = buf_q;
        if (!bus.cpu_req) begin
          if (cnt_q == len_q - ONE) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ONE;
            state_d = RD;
          end
        end
      end

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_c;

  mem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_port_mux (
    .reset       (reset),
    .cpu_req     (bus.cpu_req),
    .cpu_wr_en   (bus.cpu_wr_en),
    .cpu_memread (bus.cpu_memread),
    .cpu_addr    (bus.cpu_addr),
    .cpu_din     (bus.cpu_din),
    .eng_wr_en   (eng_wr_en),
    .eng_read    (eng_read),
    .eng_addr    (eng_addr),
    .eng_din     (eng_din),
    .mem_wr_en   (bus.mem_wr_en),
    .mem_read    (bus.mem_read),
    .mem_addr    (bus.mem_addr),
    .mem_din     (bus.mem_din)
  );

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Directed bench for mem_copy_ctrl with a 256x8 memory model behind the shared port.
// Latency: cycle k of a copy is the cycle after edge k-1, edge 0 being the edge that samples start.
// Backpressure: CPU stalls are injected per cycle through cpu_req.
module tb_mem_copy_ctrl;
  import mem_ctrl_pkg::*;

  logic clk;
  logic reset;

  mem_copy_ctrl_if #(.AW(ADDR_W), .DW(DATA_W)) bus ();

  mem_copy_ctrl #(.AW(ADDR_W), .DW(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: combinational read, write on posedge when mem_wr_en is high.
  logic [7:0] mem [256];
  int         wr_pulse_cnt = 0;

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_wr_en && !bus.cpu_req) wr_pulse_cnt <= wr_pulse_cnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int r_done_cyc;
  int r_done_n;
  int r_busy_first;
  int r_busy_n;
  int r_wr_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.src         = 8'h00;
    bus.dst         = 8'h00;
    bus.len         = 8'h00;
    bus.cpu_req     = 1'b0;
    bus.cpu_wr_en   = 1'b0;
    bus.cpu_memread = 1'b0;
    bus.cpu_addr    = 8'h00;
    bus.cpu_din     = 8'h00;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_wr_en = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_din   = d;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Runs one copy over a bounded window. start_at: cycle in which a second (to be ignored)
  // start is pulsed; stall_at/stall_n: CPU writes 5A to 0x80 in those cycles; abort_at: reset
  // cycle with a CPU write of EE to 0x42 that must be blocked. 0 disables each.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int start_at, input int stall_at, input int stall_n,
                          input int abort_at);
    int  ncyc;
    int  wr0;
    bit  stall;
    ncyc = 2 * int'(l) + 1 + stall_n + 3;
    r_done_cyc = -1; r_done_n = 0; r_busy_first = -1; r_busy_n = 0;
    @(posedge clk); #1;
    idle_inputs();
    bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l;
    wr0 = wr_pulse_cnt;
    @(posedge clk);
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      #1;
      idle_inputs();
      reset = 1'b0;
      if (cyc == start_at) begin
        bus.start = 1'b1; bus.src = 8'h30; bus.dst = 8'h60; bus.len = 8'd5;
      end
      stall = (stall_n > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_n);
      if (stall) begin
        bus.cpu_req = 1'b1; bus.cpu_wr_en = 1'b1; bus.cpu_addr = 8'h80; bus.cpu_din = 8'h5A;
      end
      if (cyc == abort_at) begin
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_wr_en = 1'b1; bus.cpu_addr = 8'h42; bus.cpu_din = 8'hEE;
      end
      #1;
      if (stall) begin
        chk("stall_mem_addr", bus.mem_addr, 8'h80);
        chk("stall_mem_din", bus.mem_din, 8'h5A);
      end
      if (cyc == abort_at) chk("reset_cycle_wr_en", bus.mem_wr_en, 1'b0);
      if (bus.busy) begin
        r_busy_n++;
        if (r_busy_first < 0) r_busy_first = cyc;
      end
      if (bus.done) begin
        r_done_n++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    idle_inputs();
    r_wr_n = wr_pulse_cnt - wr0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 8'h00);

    // CPU read passthrough while idle.
    bus.cpu_req = 1'b1; bus.cpu_memread = 1'b1; bus.cpu_addr = 8'h11;
    #1;
    chk("cpu_rd_mem_read", bus.mem_read, 1'b1);
    chk("cpu_rd_mem_addr", bus.mem_addr, 8'h11);
    chk("cpu_rd_mem_wr_en", bus.mem_wr_en, 1'b0);
    idle_inputs();

    cpu_write(8'h10, 8'hA1);
    cpu_write(8'h11, 8'hB2);
    cpu_write(8'h12, 8'hC3);
    cpu_write(8'h13, 8'hD4);

    // 1: plain copy, stray start during RD must be ignored.
    run_copy(8'h10, 8'h40, 8'd4, 3, 0, 0, 0);
    chk("t1_done_cyc", r_done_cyc, 9);
    chk("t1_done_n", r_done_n, 1);
    chk("t1_busy_first", r_busy_first, 1);
    chk("t1_busy_n", r_busy_n, 9);
    chk("t1_wr_n", r_wr_n, 4);
    chk("t1_m40", mem[8'h40], 8'hA1);
    chk("t1_m41", mem[8'h41], 8'hB2);
    chk("t1_m42", mem[8'h42], 8'hC3);
    chk("t1_m43", mem[8'h43], 8'hD4);

    // 2: same copy with a 3-cycle CPU write burst starting in a WR cycle.
    for (int i = 0; i < 4; i++) cpu_write(8'(8'h40 + i), 8'h00);
    run_copy(8'h10, 8'h40, 8'd4, 0, 4, 3, 0);
    chk("t2_done_cyc", r_done_cyc, 12);
    chk("t2_done_n", r_done_n, 1);
    chk("t2_busy_n", r_busy_n, 12);
    chk("t2_wr_n", r_wr_n, 4);
    chk("t2_m80", mem[8'h80], 8'h5A);
    chk("t2_m40", mem[8'h40], 8'hA1);
    chk("t2_m41", mem[8'h41], 8'hB2);
    chk("t2_m42", mem[8'h42], 8'hC3);
    chk("t2_m43", mem[8'h43], 8'hD4);

    // 3: source wraps FF->00.
    cpu_write(8'hFE, 8'h11);
    cpu_write(8'hFF, 8'h22);
    cpu_write(8'h00, 8'h33);
    cpu_write(8'h01, 8'h44);
    run_copy(8'hFE, 8'h20, 8'd4, 0, 0, 0, 0);
    chk("t3_done_cyc", r_done_cyc, 9);
    chk("t3_m20", mem[8'h20], 8'h11);
    chk("t3_m21", mem[8'h21], 8'h22);
    chk("t3_m22", mem[8'h22], 8'h33);
    chk("t3_m23", mem[8'h23], 8'h44);

    // 4: len=0, start re-pulsed during DONE must be ignored.
    run_copy(8'h10, 8'h50, 8'd0, 1, 0, 0, 0);
    chk("t4_done_cyc", r_done_cyc, 1);
    chk("t4_done_n", r_done_n, 1);
    chk("t4_busy_n", r_busy_n, 1);
    chk("t4_wr_n", r_wr_n, 0);

    // 5: reset in cycle 5 (after the 2nd write); CPU write attempted in that reset cycle.
    for (int i = 0; i < 4; i++) cpu_write(8'(8'h40 + i), 8'h00);
    run_copy(8'h10, 8'h40, 8'd4, 0, 0, 0, 5);
    chk("t5_done_n", r_done_n, 0);
    chk("t5_wr_n", r_wr_n, 2);
    chk("t5_busy_after", bus.busy, 1'b0);
    chk("t5_m40", mem[8'h40], 8'hA1);
    chk("t5_m41", mem[8'h41], 8'hB2);
    chk("t5_m42", mem[8'h42], 8'h00);
    chk("t5_m43", mem[8'h43], 8'h00);

    // 6: overlapping forward copy replicates the first byte.
    run_copy(8'h10, 8'h11, 8'd3, 0, 0, 0, 0);
    chk("t6_done_cyc", r_done_cyc, 7);
    chk("t6_m11", mem[8'h11], 8'hA1);
    chk("t6_m12", mem[8'h12], 8'hA1);
    chk("t6_m13", mem[8'h13], 8'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
